// File: rtl/vga_scan_controller_if.sv
// ---------------------------------------------------------------------------
// vga_scan_controller_if
// Bundle of raster-timing signals that the VGA scan controller drives toward
// the VGA DAC and toward the colour mapper / game logic.
//   VGA_CLK      25 MHz pixel clock (half of the system clock)
//   VGA_HS/VS    horizontal / vertical sync, active low
//   VGA_BLANK_N  1 on visible pixels, 0 during blanking
//   VGA_SYNC_N   no sync-on-green, held 0
//   DrawX/DrawY  current raster column / row
//   pix_en       one-system-clock strobe on cycles where the counters advance
//   line_start   one-cycle strobe after DrawX wraps to 0
//   frame_start  one-cycle strobe after (DrawX, DrawY) wraps to (0, 0)
//   vblank       high while DrawY is below the visible area
// master: the controller that drives the bundle; slave: any consumer.
// ---------------------------------------------------------------------------
interface vga_scan_controller_if;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       pix_en;
  logic       line_start;
  logic       frame_start;
  logic       vblank;

  modport master (
    output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    output DrawX, DrawY, pix_en, line_start, frame_start, vblank
  );

  modport slave (
    input VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    input DrawX, DrawY, pix_en, line_start, frame_start, vblank
  );
endinterface

// File: rtl/vga_scan_controller.sv
// ---------------------------------------------------------------------------
// vga_scan_controller
// Generates 640x480 @ 60 Hz VGA raster timing from the 50 MHz system clock.
// A divide-by-two phase bit forms the pixel clock; horizontal and vertical
// counters step once per pixel and drive DrawX/DrawY directly.  Sync, blank
// and vblank are registered from the *next* counter values so they change on
// the same edge as DrawX/DrawY.
// Ports:
//   Clk      in   50 MHz system clock
//   Reset_n  in   asynchronous, active-low reset
//   vga      master side of vga_scan_controller_if (timing outputs)
// ---------------------------------------------------------------------------
module vga_scan_controller #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  vga_scan_controller_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       phase;
  logic       pix_en_q;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hs_q;
  logic       vs_q;
  logic       blank_n_q;
  logic       vblank_q;
  logic       line_start_q;
  logic       frame_start_q;

  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;

  // Next counter values. The vertical counter only moves when the
  // horizontal counter wraps, and both hold on non-pixel cycles.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_nxt  = h_cnt;
    v_nxt  = v_cnt;
    if (pix_en_q) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = v_wrap ? '0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end
  end

  // Decoded outputs are registered from the next counter values so that
  // they line up with DrawX/DrawY on the same edge. The strobes mark the
  // cycle right after a wrap, which is exactly the edge that wraps while
  // pix_en is high.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      phase         <= 1'b0;
      pix_en_q      <= 1'b0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b1;
      vblank_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      phase         <= ~phase;
      pix_en_q      <= ~phase;
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      hs_q          <= ~((h_nxt >= HS_START) && (h_nxt < HS_END));
      vs_q          <= ~((v_nxt >= VS_START) && (v_nxt < VS_END));
      blank_n_q     <= (h_nxt < H_VIS_END) && (v_nxt < V_VIS_END);
      vblank_q      <= (v_nxt >= V_VIS_END);
      line_start_q  <= pix_en_q && h_wrap;
      frame_start_q <= pix_en_q && h_wrap && v_wrap;
    end
  end

  assign vga.VGA_CLK     = phase;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = blank_n_q;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.DrawX       = h_cnt;
  assign vga.DrawY       = v_cnt;
  assign vga.pix_en      = pix_en_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.vblank      = vblank_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_controller
// Bench for vga_scan_controller. One instance uses the real 640x480 timing
// for power-up and single-line behaviour; a second instance uses a shrunken
// raster so that whole frames and a mid-frame reset fit in a short run.
// Expected values come from an arithmetic model: the number of Clk cycles
// since reset release fixes the pixel index, and from that the coordinates,
// sync, blank and strobes follow directly from the timing parameters.
// ---------------------------------------------------------------------------
module tb_vga_scan_controller;

  typedef struct packed {
    logic       vga_clk;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic       sync_n;
    logic       pix_en;
    logic       line_start;
    logic       frame_start;
    logic       vblank;
    logic [9:0] x;
    logic [9:0] y;
  } vga_t;

  logic Clk = 1'b0;
  logic rst_full_n = 1'b0;
  logic rst_small_n = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int k_full = 0;
  int k_small = 0;

  always #10 Clk = ~Clk;

  vga_scan_controller_if bus_full();
  vga_scan_controller_if bus_small();

  vga_scan_controller dut_full (
    .Clk     (Clk),
    .Reset_n (rst_full_n),
    .vga     (bus_full)
  );

  vga_scan_controller #(
    .H_VISIBLE (20), .H_FRONT (3), .H_SYNC (4), .H_BACK (5),
    .V_VISIBLE (10), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
  ) dut_small (
    .Clk     (Clk),
    .Reset_n (rst_small_n),
    .vga     (bus_small)
  );

  // Cycles elapsed since reset release, per instance.
  always @(posedge Clk or negedge rst_full_n)
    if (!rst_full_n) k_full <= 0; else k_full <= k_full + 1;

  always @(posedge Clk or negedge rst_small_n)
    if (!rst_small_n) k_small <= 0; else k_small <= k_small + 1;

  // Reference: cycle k after release has advanced floor(k/2) pixels.
  function automatic vga_t model(input int k, input int hv, input int hf,
                                 input int hsw, input int hb, input int vv,
                                 input int vf, input int vsw, input int vb);
    vga_t e;
    int ht, vt, p, x, y;
    logic strobe;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p  = k / 2;
    x  = p % ht;
    y  = (p / ht) % vt;
    strobe        = (k >= 2) && (k % 2 == 0) && (x == 0);
    e.vga_clk     = (k % 2 == 1);
    e.pix_en      = (k % 2 == 1);
    e.hs          = !((x >= hv + hf) && (x < hv + hf + hsw));
    e.vs          = !((y >= vv + vf) && (y < vv + vf + vsw));
    e.blank_n     = (x < hv) && (y < vv);
    e.sync_n      = 1'b0;
    e.line_start  = strobe;
    e.frame_start = strobe && (y == 0);
    e.vblank      = (y >= vv);
    e.x           = 10'(x);
    e.y           = 10'(y);
    return e;
  endfunction

  function automatic vga_t model_full(input int k);
    return model(k, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic vga_t model_small(input int k);
    return model(k, 20, 3, 4, 5, 10, 2, 2, 3);
  endfunction

  function automatic vga_t reset_vals();
    vga_t e;
    e         = '0;
    e.hs      = 1'b1;
    e.vs      = 1'b1;
    e.blank_n = 1'b1;
    return e;
  endfunction

  function automatic vga_t obs_full();
    vga_t o;
    o.vga_clk     = bus_full.VGA_CLK;
    o.hs          = bus_full.VGA_HS;
    o.vs          = bus_full.VGA_VS;
    o.blank_n     = bus_full.VGA_BLANK_N;
    o.sync_n      = bus_full.VGA_SYNC_N;
    o.pix_en      = bus_full.pix_en;
    o.line_start  = bus_full.line_start;
    o.frame_start = bus_full.frame_start;
    o.vblank      = bus_full.vblank;
    o.x           = bus_full.DrawX;
    o.y           = bus_full.DrawY;
    return o;
  endfunction

  function automatic vga_t obs_small();
    vga_t o;
    o.vga_clk     = bus_small.VGA_CLK;
    o.hs          = bus_small.VGA_HS;
    o.vs          = bus_small.VGA_VS;
    o.blank_n     = bus_small.VGA_BLANK_N;
    o.sync_n      = bus_small.VGA_SYNC_N;
    o.pix_en      = bus_small.pix_en;
    o.line_start  = bus_small.line_start;
    o.frame_start = bus_small.frame_start;
    o.vblank      = bus_small.vblank;
    o.x           = bus_small.DrawX;
    o.y           = bus_small.DrawY;
    return o;
  endfunction

  // Both instances held in reset while Clk runs.
  task automatic test_reset();
    vga_t got;
    rst_full_n  = 1'b0;
    rst_small_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      repeat (2) @(negedge Clk);
      got = obs_full();
      n_checks++;
      if (got !== reset_vals()) begin
        n_fail++;
        $display("[TB] FAIL reset_full: got %h required %h", got, reset_vals());
      end
      got = obs_small();
      n_checks++;
      if (got !== reset_vals()) begin
        n_fail++;
        $display("[TB] FAIL reset_small: got %h required %h", got, reset_vals());
      end
    end
  endtask

  // First cycles after release on the full-size raster.
  task automatic test_power_up();
    vga_t got, exp;
    rst_full_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      got = obs_full();
      exp = model_full(k_full);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("[TB] FAIL power_up k=%0d: got %h required %h", k_full, got, exp);
      end
    end
  endtask

  // Full first line plus the wrap into line 1.
  task automatic test_line();
    vga_t got, exp;
    int hs_low = 0;
    int first_hs_x = -1;
    int line_starts = 0;
    int y_at_wrap = -1;
    int x_at_wrap = -1;
    for (int i = 0; i < 2000 && k_full < 1610; i++) begin
      @(negedge Clk);
      got = obs_full();
      exp = model_full(k_full);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("[TB] FAIL line k=%0d: got %h (x=%0d y=%0d) required %h (x=%0d y=%0d)",
                 k_full, got, got.x, got.y, exp, exp.x, exp.y);
      end
      if (got.hs === 1'b0) begin
        if (first_hs_x < 0) first_hs_x = int'(got.x);
        hs_low++;
      end
      if (got.line_start === 1'b1) line_starts++;
      if (k_full == 1600) begin
        x_at_wrap = int'(got.x);
        y_at_wrap = int'(got.y);
      end
    end
    n_checks++;
    if (hs_low != 192) begin
      n_fail++;
      $display("[TB] FAIL hs_width: got %0d cycles required 192", hs_low);
    end
    n_checks++;
    if (first_hs_x != 656) begin
      n_fail++;
      $display("[TB] FAIL hs_start_x: got %0d required 656", first_hs_x);
    end
    n_checks++;
    if (line_starts != 1) begin
      n_fail++;
      $display("[TB] FAIL line_start_count: got %0d required 1", line_starts);
    end
    n_checks++;
    if (x_at_wrap != 0 || y_at_wrap != 1) begin
      n_fail++;
      $display("[TB] FAIL line_wrap: got x=%0d y=%0d required x=0 y=1", x_at_wrap, y_at_wrap);
    end
  endtask

  // Two whole frames on the shrunken raster (32x17 pixels, 1088 cycles).
  task automatic test_frame();
    vga_t got, exp;
    int frames = 0;
    int first_fs = -1;
    int second_fs = -1;
    int vs_pix = 0;
    int blank_pix = 0;
    rst_small_n = 1'b1;
    for (int i = 0; i < 2400 && k_small < 2186; i++) begin
      @(negedge Clk);
      got = obs_small();
      exp = model_small(k_small);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("[TB] FAIL frame k=%0d: got %h (x=%0d y=%0d) required %h (x=%0d y=%0d)",
                 k_small, got, got.x, got.y, exp, exp.x, exp.y);
      end
      if (got.frame_start === 1'b1) begin
        frames++;
        if (first_fs < 0) first_fs = k_small;
        else if (second_fs < 0) second_fs = k_small;
      end
      if (k_small <= 1088 && got.pix_en === 1'b1) begin
        if (got.vs === 1'b0) vs_pix++;
        if (got.blank_n === 1'b1) blank_pix++;
      end
      if (exp.x == 19 && exp.y == 9) begin
        n_checks++;
        if (got.blank_n !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL blank_last_visible: got %b required 1", got.blank_n);
        end
      end
      if (exp.x == 20 && exp.y == 9) begin
        n_checks++;
        if (got.blank_n !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL blank_right_edge: got %b required 0", got.blank_n);
        end
      end
      if (exp.x == 0 && exp.y == 10) begin
        n_checks++;
        if (got.blank_n !== 1'b0 || got.vblank !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL vblank_rise: got blank_n=%b vblank=%b required 0 1",
                   got.blank_n, got.vblank);
        end
      end
      if (exp.x == 0 && exp.y == 0 && k_small >= 2) begin
        n_checks++;
        if (got.vblank !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL vblank_fall: got %b required 0", got.vblank);
        end
      end
    end
    n_checks++;
    if (frames != 2) begin
      n_fail++;
      $display("[TB] FAIL frame_count: got %0d required 2", frames);
    end
    n_checks++;
    if (second_fs - first_fs != 1088) begin
      n_fail++;
      $display("[TB] FAIL frame_period: got %0d required 1088", second_fs - first_fs);
    end
    n_checks++;
    if (vs_pix != 64) begin
      n_fail++;
      $display("[TB] FAIL vs_width: got %0d pixels required 64", vs_pix);
    end
    n_checks++;
    if (blank_pix != 200) begin
      n_fail++;
      $display("[TB] FAIL visible_pixels: got %0d required 200", blank_pix);
    end
  endtask

  // Asynchronous reset in the middle of a Clk half-period, then a restart
  // that must retrace the power-up sequence.
  task automatic test_mid_reset();
    vga_t got, exp;
    bit found = 1'b0;
    for (int i = 0; i < 1300 && !found; i++) begin
      @(negedge Clk);
      got = obs_small();
      if (got.x == 10'd7 && got.y == 10'd5) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_wait: got timeout required DrawX=7 DrawY=5");
    end
    #3;
    rst_small_n = 1'b0;
    #1;
    got = obs_small();
    n_checks++;
    if (got !== reset_vals()) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_async: got %h required %h", got, reset_vals());
    end
    repeat (2) @(negedge Clk);
    rst_small_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      got = obs_small();
      exp = model_small(k_small);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("[TB] FAIL restart k=%0d: got %h required %h", k_small, got, exp);
      end
    end
  endtask

  // Random-length hold in reset and random run length, both instances.
  task automatic test_random_restart();
    vga_t got, exp;
    for (int r = 0; r < 3; r++) begin
      @(negedge Clk);
      rst_full_n = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge Clk);
      rst_full_n = 1'b1;
      for (int i = 0; i < int'($urandom_range(50, 400)); i++) begin
        @(negedge Clk);
        got = obs_full();
        exp = model_full(k_full);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("[TB] FAIL random_restart k=%0d: got %h required %h", k_full, got, exp);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] vga_scan_controller bench start");
    test_reset();
    test_power_up();
    test_line();
    test_frame();
    test_mid_reset();
    test_random_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
- Generates 640x480 @ 60 Hz VGA raster timing from the 50 MHz system clock.
- Produces the DrawX/DrawY pixel coordinates that the colour mapper and sprite/maze logic consume, and the sync, blank and pixel-clock strobes that drive the VGA DAC.
- Emits frame and line boundary pulses so game-state logic (pac-man/ghost motion, food updates) can update only in vertical blank.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- Clk  in  1  50 MHz system clock
- Reset_n  in  1  asynchronous, active-low reset
- VGA_CLK  out  1  25 MHz pixel clock to DAC
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  1 = visible pixel, 0 = blanking
- VGA_SYNC_N  out  1  tied 0 (no sync-on-green)
- DrawX  out  10  current column, 0..H_TOTAL-1
- DrawY  out  10  current row, 0..V_TOTAL-1
- pix_en  out  1  one-Clk strobe when DrawX/DrawY advance
- line_start  out  1  one-Clk strobe when DrawX wraps to 0
- frame_start  out  1  one-Clk strobe when (DrawX,DrawY) wraps to (0,0)
- vblank  out  1  1 while DrawY >= V_VISIBLE

Behaviour:
- Reset and clocking
  - One clock (Clk). Reset is asynchronous and active-low (Reset_n). All state resets immediately on Reset_n = 0, independent of Clk.
  - H_TOTAL = sum of H_* (800). V_TOTAL = sum of V_* (525).
  - Reset values: phase = 0, VGA_CLK = 0, h_cnt = 0, v_cnt = 0, DrawX = 0, DrawY = 0, VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 1, pix_en = 0, line_start = 0, frame_start = 0, vblank = 0, VGA_SYNC_N = 0.
- Pixel clock
  - phase toggles every Clk edge. VGA_CLK = phase.
  - pix_en = 1 in Clk cycles where phase = 1, so pix_en is high every other cycle starting with the second cycle after reset release.
- Counters
  - On each Clk edge with pix_en = 1:
    - If h_cnt = H_TOTAL-1, h_cnt <= 0 and v_cnt advances; otherwise h_cnt <= h_cnt + 1.
    - v_cnt advances as: if v_cnt = V_TOTAL-1 then 0, else v_cnt + 1.
  - Counters hold when pix_en = 0. No other values are ever reached; 10-bit widths never overflow.
- Outputs
  - DrawX = h_cnt and DrawY = v_cnt, driven directly from registers.
  - VGA_HS, VGA_VS, VGA_BLANK_N and vblank are registered. They are computed from the next counter values so they change on the same edge as DrawX/DrawY, with zero relative skew.
  - VGA_HS = 0 iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - VGA_VS = 0 iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - VGA_BLANK_N = 1 iff h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
  - vblank = (v_cnt >= V_VISIBLE).
- Strobes
  - line_start is asserted for exactly one Clk cycle, the cycle immediately after the edge on which h_cnt wraps to 0.
  - frame_start is asserted for exactly one Clk cycle, the cycle immediately after the edge on which both counters wrap to 0. It coincides with line_start on that cycle.
  - Neither strobe asserts on reset release.
- Reset mid-frame: asynchronous return to the reset values above. Scanning restarts at (0,0) with the same phase sequence as at power-up.
- Latency: zero added. Downstream combinational colour logic sees DrawX/DrawY and VGA_BLANK_N in the same cycle.

Test Plan:
- Reset release -> VGA_CLK toggles 0,1,0,1 on successive Clk cycles; first pix_en in cycle 2; DrawX steps 0->1 on the first pix_en edge; DrawY = 0.
- Run 1600 Clk cycles -> DrawX wraps 799->0 and DrawY = 1; line_start high exactly 1 cycle; VGA_HS low for exactly 192 Clk cycles, beginning when DrawX = 656.
- Full frame (840000 Clk cycles) -> frame_start pulses once per frame, period exactly 840000 cycles; VGA_VS low only for DrawY = 490..491 (3200 Clk cycles).
- Blank check across a frame -> VGA_BLANK_N = 1 for exactly 307200 pixel periods; at (639,479) it is 1; at (640,479) and (0,480) it is 0; vblank rises at DrawY = 480 and falls at DrawY = 0.
- Assert Reset_n = 0 asynchronously at DrawX = 300, DrawY = 200, mid-Clk -> outputs reach reset values without a Clk edge; after release, the sequence matches the power-up sequence exactly.
- Sync-vs-coordinate alignment, checked every edge -> VGA_HS/VGA_VS/VGA_BLANK_N always equal the decode of the current DrawX/DrawY; VGA_SYNC_N is constant 0.
